// File: rtl/logged_sync_pkg.sv
// Shared types and constants for the logged_sync event arbiter slice.
package logged_sync_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } arb_state_e;

  localparam int unsigned NCH_DEF = 4;
  localparam int unsigned IDW_DEF = 2;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/logged_evt_arb_if.sv
// Launch/bundled-ID/sync-back handshake between the arbiter and the logged_sync crossing.
interface logged_evt_arb_if #(
  parameter int unsigned IDW = 2
);
  logic           evt_o;
  logic [IDW-1:0] evt_id_o;
  logic           sync_back_i;

  modport master (output evt_o, output evt_id_o, input  sync_back_i);
  modport slave  (input  evt_o, input  evt_id_o, output sync_back_i);
endinterface

// File: rtl/logged_evt_rr_pick.sv
// Combinational round-robin picker: first pending index strictly above ptr_i, wrapping.
module logged_evt_rr_pick #(
  parameter int unsigned NCH = 4,
  parameter int unsigned IDW = 2
) (
  input  logic [NCH-1:0] pend_i,
  input  logic [IDW-1:0] ptr_i,
  output logic           gnt_vld_o,
  output logic [IDW-1:0] gnt_idx_o
);

  int unsigned    idx;
  logic [NCH-1:0] sh;

  always_comb begin
    gnt_vld_o = 1'b0;
    gnt_idx_o = '0;
    idx       = 0;
    sh        = '0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      idx = (int'(ptr_i) + k) % NCH;
      sh  = pend_i >> idx;
      if (!gnt_vld_o && sh[0]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/logged_evt_arb.sv
// Round-robin scheduler sharing one logged_sync crossing among NCH event sources.
// Optional watchdog on the sync-back wait: define LOGSYNC_TIMEOUT_EN.
module logged_evt_arb
  import logged_sync_pkg::*;
#(
  parameter int unsigned NCH    = NCH_DEF,
  parameter int unsigned IDW    = IDW_DEF,
  parameter int unsigned TO_CYC = 64
) (
  input  logic                 A_CLK,
  input  logic                 A_RST,
  input  logic [NCH-1:0]       req_i,
  logged_evt_arb_if.master     xif,
  output logic                 busy_o,
  output logic [NCH-1:0]       pend_o,
  output logic [NCH-1:0]       coal_o,
  input  logic [NCH-1:0]       coal_clr_i,
  output logic                 timeout_o
);

  if (IDW < clog2(NCH) || NCH < 1 || NCH > 16 || TO_CYC < 1) begin : g_param_chk
    $error("logged_evt_arb: illegal NCH/IDW/TO_CYC combination");
  end

  arb_state_e     state_q;
  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] coal_q, coal_d;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] evt_id_q;
  logic           evt_q;
  logic           gnt_vld;
  logic [IDW-1:0] gnt_idx;
  logic [NCH-1:0] gnt_mask;
  logic           to_hit;

  logged_evt_rr_pick #(.NCH(NCH), .IDW(IDW)) u_pick (
    .pend_i    (pend_q),
    .ptr_i     (ptr_q),
    .gnt_vld_o (gnt_vld),
    .gnt_idx_o (gnt_idx)
  );

  // A request landing on the granted channel re-arms pend, so it is never counted as coalesced.
  always_comb begin
    gnt_mask = '0;
    if (state_q == IDLE && gnt_vld) gnt_mask = NCH'(1) << gnt_idx;
    pend_d = (pend_q & ~gnt_mask) | req_i;
    coal_d = (coal_q & ~coal_clr_i) | (req_i & pend_q & ~gnt_mask);
  end

  always_ff @(posedge A_CLK or posedge A_RST) begin
    if (A_RST) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      coal_q   <= '0;
      ptr_q    <= IDW'(NCH - 1);
      evt_id_q <= '0;
      evt_q    <= 1'b0;
    end else begin
      pend_q <= pend_d;
      coal_q <= coal_d;
      evt_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            state_q  <= LAUNCH;
            evt_q    <= 1'b1;
            evt_id_q <= gnt_idx;
            ptr_q    <= gnt_idx;
          end
        end
        LAUNCH:  state_q <= WAIT_HI;
        WAIT_HI: begin
          if (to_hit)                state_q <= IDLE;
          else if (xif.sync_back_i)  state_q <= WAIT_LO;
        end
        WAIT_LO: begin
          if (to_hit)                state_q <= IDLE;
          else if (!xif.sync_back_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef LOGSYNC_TIMEOUT_EN
  localparam int unsigned CNTW = (clog2(TO_CYC) > 0) ? clog2(TO_CYC) : 1;

  logic [CNTW-1:0] cnt_q;
  logic            timeout_q;
  logic            stay;

  // Counter only advances while the FSM holds in a wait state; any transition restarts it.
  assign stay   = (state_q == WAIT_HI && !xif.sync_back_i) ||
                  (state_q == WAIT_LO &&  xif.sync_back_i);
  assign to_hit = (state_q == WAIT_HI || state_q == WAIT_LO) &&
                  (cnt_q == CNTW'(TO_CYC - 1));

  always_ff @(posedge A_CLK or posedge A_RST) begin
    if (A_RST) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= (stay && !to_hit) ? cnt_q + CNTW'(1) : '0;
      timeout_q <= timeout_q | to_hit;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign to_hit    = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign xif.evt_o    = evt_q;
  assign xif.evt_id_o = evt_id_q;
  assign busy_o       = (state_q != IDLE);
  assign pend_o       = pend_q;
  assign coal_o       = coal_q;

endmodule

// File: tb/tb_logged_evt_arb.sv
// Directed self-checking bench for logged_evt_arb (NCH=4, IDW=2, TO_CYC=64).
module tb_logged_evt_arb;

  logic       A_CLK;
  logic       A_RST;
  logic [3:0] req_i;
  logic [3:0] coal_clr_i;
  logic       busy_o;
  logic [3:0] pend_o;
  logic [3:0] coal_o;
  logic       timeout_o;

  logged_evt_arb_if #(.IDW(2)) xif ();

  logged_evt_arb #(.NCH(4), .IDW(2), .TO_CYC(64)) dut (
    .A_CLK      (A_CLK),
    .A_RST      (A_RST),
    .req_i      (req_i),
    .xif        (xif),
    .busy_o     (busy_o),
    .pend_o     (pend_o),
    .coal_o     (coal_o),
    .coal_clr_i (coal_clr_i),
    .timeout_o  (timeout_o)
  );

  initial A_CLK = 1'b0;
  always #5 A_CLK = ~A_CLK;

  typedef struct {
    bit         rst;
    logic [3:0] req;
    logic       sb;
    logic [3:0] clr;
    logic       evt;
    logic [1:0] id;
    logic       busy;
    logic [3:0] pend;
    logic [3:0] coal;
  } vec_t;

  vec_t vq[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input bit rst, input logic [3:0] req, input logic sb, input logic [3:0] clr,
                     input logic evt, input logic [1:0] id, input logic busy,
                     input logic [3:0] pend, input logic [3:0] coal);
    vq.push_back('{rst, req, sb, clr, evt, id, busy, pend, coal});
  endtask

  task automatic step();
    @(posedge A_CLK);
    #1;
  endtask

  task automatic do_reset(input string tag);
    req_i = '0; coal_clr_i = '0; xif.sync_back_i = 1'b0;
    A_RST = 1'b1;
    #2;
    check({tag, ".rst.evt"},  32'(xif.evt_o),    32'd0);
    check({tag, ".rst.id"},   32'(xif.evt_id_o), 32'd0);
    check({tag, ".rst.busy"}, 32'(busy_o),       32'd0);
    check({tag, ".rst.pend"}, 32'(pend_o),       32'd0);
    check({tag, ".rst.coal"}, 32'(coal_o),       32'd0);
    check({tag, ".rst.to"},   32'(timeout_o),    32'd0);
    step();
    A_RST = 1'b0;
  endtask

  initial begin
    int n;
    A_RST = 1'b1; req_i = '0; coal_clr_i = '0; xif.sync_back_i = 1'b0;
    step();

    // A: single event on channel 2, sync-back high for 4 cycles
    add(1, 4'b0100, 0, 4'b0000, 0, 2'd0, 0, 4'b0100, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 1, 2'd2, 1, 4'b0000, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 0, 2'd2, 1, 4'b0000, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 0, 2'd2, 1, 4'b0000, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 0, 2'd2, 1, 4'b0000, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 0, 2'd2, 1, 4'b0000, 4'b0000);
    add(0, 4'b0000, 1, 4'b0000, 0, 2'd2, 1, 4'b0000, 4'b0000);
    add(0, 4'b0000, 1, 4'b0000, 0, 2'd2, 1, 4'b0000, 4'b0000);
    add(0, 4'b0000, 1, 4'b0000, 0, 2'd2, 1, 4'b0000, 4'b0000);
    add(0, 4'b0000, 1, 4'b0000, 0, 2'd2, 1, 4'b0000, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 0, 2'd2, 0, 4'b0000, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 0, 2'd2, 0, 4'b0000, 4'b0000);

    // B: all four at once -> IDs 0,1,2,3 in order
    add(1, 4'b1111, 0, 4'b0000, 0, 2'd0, 0, 4'b1111, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      logic [3:0] pl;
      pl = 4'b1111 << (k + 1);
      add(0, 4'b0000, 0, 4'b0000, 1, 2'(k), 1, pl, 4'b0000);
      add(0, 4'b0000, 0, 4'b0000, 0, 2'(k), 1, pl, 4'b0000);
      add(0, 4'b0000, 1, 4'b0000, 0, 2'(k), 1, pl, 4'b0000);
      add(0, 4'b0000, 0, 4'b0000, 0, 2'(k), 0, pl, 4'b0000);
    end
    add(0, 4'b0000, 0, 4'b0000, 0, 2'd3, 0, 4'b0000, 4'b0000);

    // C: two ch1 events while busy on ch0 merge into one launch
    add(1, 4'b0001, 0, 4'b0000, 0, 2'd0, 0, 4'b0001, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 1, 2'd0, 1, 4'b0000, 4'b0000);
    add(0, 4'b0010, 0, 4'b0000, 0, 2'd0, 1, 4'b0010, 4'b0000);
    add(0, 4'b0010, 0, 4'b0000, 0, 2'd0, 1, 4'b0010, 4'b0010);
    add(0, 4'b0000, 1, 4'b0000, 0, 2'd0, 1, 4'b0010, 4'b0010);
    add(0, 4'b0000, 0, 4'b0000, 0, 2'd0, 0, 4'b0010, 4'b0010);
    add(0, 4'b0000, 0, 4'b0000, 1, 2'd1, 1, 4'b0000, 4'b0010);
    add(0, 4'b0000, 0, 4'b0000, 0, 2'd1, 1, 4'b0000, 4'b0010);
    add(0, 4'b0000, 1, 4'b0000, 0, 2'd1, 1, 4'b0000, 4'b0010);
    add(0, 4'b0000, 0, 4'b0000, 0, 2'd1, 0, 4'b0000, 4'b0010);
    add(0, 4'b0000, 0, 4'b0010, 0, 2'd1, 0, 4'b0000, 4'b0000);

    // D: req and grant of ch3 in the same cycle, set-wins clear, sync_back ignored in LAUNCH
    add(1, 4'b1000, 0, 4'b0000, 0, 2'd0, 0, 4'b1000, 4'b0000);
    add(0, 4'b1000, 0, 4'b0000, 1, 2'd3, 1, 4'b1000, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 0, 2'd3, 1, 4'b1000, 4'b0000);
    add(0, 4'b0000, 1, 4'b0000, 0, 2'd3, 1, 4'b1000, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 0, 2'd3, 0, 4'b1000, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 1, 2'd3, 1, 4'b0000, 4'b0000);
    add(0, 4'b1000, 0, 4'b0000, 0, 2'd3, 1, 4'b1000, 4'b0000);
    add(0, 4'b1000, 0, 4'b1000, 0, 2'd3, 1, 4'b1000, 4'b1000);
    add(0, 4'b0000, 1, 4'b1000, 0, 2'd3, 1, 4'b1000, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 0, 2'd3, 0, 4'b1000, 4'b0000);
    add(0, 4'b0000, 1, 4'b0000, 1, 2'd3, 1, 4'b0000, 4'b0000);
    add(0, 4'b0000, 1, 4'b0000, 0, 2'd3, 1, 4'b0000, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 0, 2'd3, 1, 4'b0000, 4'b0000);
    add(0, 4'b0000, 1, 4'b0000, 0, 2'd3, 1, 4'b0000, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 0, 2'd3, 0, 4'b0000, 4'b0000);

    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].rst) do_reset($sformatf("v%0d", i));
      req_i = vq[i].req; xif.sync_back_i = vq[i].sb; coal_clr_i = vq[i].clr;
      step();
      req_i = '0; coal_clr_i = '0;
      check($sformatf("v%0d.evt", i),  32'(xif.evt_o),    32'(vq[i].evt));
      check($sformatf("v%0d.id", i),   32'(xif.evt_id_o), 32'(vq[i].id));
      check($sformatf("v%0d.busy", i), 32'(busy_o),       32'(vq[i].busy));
      check($sformatf("v%0d.pend", i), 32'(pend_o),       32'(vq[i].pend));
      check($sformatf("v%0d.coal", i), 32'(coal_o),       32'(vq[i].coal));
      check($sformatf("v%0d.to", i),   32'(timeout_o),    32'd0);
    end

    // E: asynchronous reset mid-WAIT_HI with pend=1010
    do_reset("E");
    req_i = 4'b0001; step();
    req_i = 4'b0000; step();
    req_i = 4'b1010; step();
    req_i = 4'b0000;
    check("E.pre.pend", 32'(pend_o), 32'b1010);
    check("E.pre.busy", 32'(busy_o), 32'd1);
    #2 A_RST = 1'b1;
    #1;
    check("E.async.evt",  32'(xif.evt_o),    32'd0);
    check("E.async.id",   32'(xif.evt_id_o), 32'd0);
    check("E.async.busy", 32'(busy_o),       32'd0);
    check("E.async.pend", 32'(pend_o),       32'd0);
    check("E.async.coal", 32'(coal_o),       32'd0);
    step();
    A_RST = 1'b0;
    req_i = 4'b0100; step();
    req_i = 4'b0000;
    check("E.post.pend", 32'(pend_o),    32'b0100);
    check("E.post.evt0", 32'(xif.evt_o), 32'd0);
    step();
    check("E.post.evt",  32'(xif.evt_o),    32'd1);
    check("E.post.id",   32'(xif.evt_id_o), 32'd2);

`ifdef LOGSYNC_TIMEOUT_EN
    // F: sync_back stuck low -> watchdog after 64 cycles in WAIT_HI, then ch1 launches
    do_reset("F");
    req_i = 4'b0011; step();
    req_i = 4'b0000; step();
    check("F.launch.id", 32'(xif.evt_id_o), 32'd0);
    n = 0;
    while (timeout_o !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check("F.to.cycles", 32'(n),      32'd65);
    check("F.to.flag",   32'(timeout_o), 32'd1);
    check("F.to.busy",   32'(busy_o), 32'd0);
    step();
    check("F.next.evt",  32'(xif.evt_o),    32'd1);
    check("F.next.id",   32'(xif.evt_id_o), 32'd1);
    check("F.to.sticky", 32'(timeout_o),    32'd1);
`else
    n = 0;
    check("F.to.tied0", 32'(timeout_o), 32'(n));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
